// File: rtl/tablero_pkg.sv
// Shared types and constants for the tic-tac-toe game-state stage:
// cell/state/winner encodings and the table of the eight winning lines.
package tablero_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_COMMIT = 2'b01,
        ST_EVAL   = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;
    localparam int BOARD_W   = 2 * NUM_CELLS;

    // Rows, columns, then both diagonals (cell indices, row-major).
    localparam logic [NUM_LINES-1:0][2:0][3:0] WIN_LINES = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic cell_t mark_of(input logic player);
        return player ? MARK_O : MARK_X;
    endfunction

    function automatic winner_t winner_of(input logic player);
        return player ? WIN_O : WIN_X;
    endfunction

endpackage

// File: rtl/linea_ganadora.sv
// Combinational line checker: flags when the given player owns all three
// cells of any row, column or diagonal of the board.
module linea_ganadora
    import tablero_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  logic               player,
    output logic               win
);

    cell_t                mark;
    logic [NUM_LINES-1:0] line_hit;

    assign mark = mark_of(player);

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            localparam int C0 = int'(WIN_LINES[gi][0]);
            localparam int C1 = int'(WIN_LINES[gi][1]);
            localparam int C2 = int'(WIN_LINES[gi][2]);
            assign line_hit[gi] = (board[2*C0 +: 2] == mark) &&
                                  (board[2*C1 +: 2] == mark) &&
                                  (board[2*C2 +: 2] == mark);
        end
    endgenerate

    assign win = |line_hit;

endmodule

// File: rtl/tablero_estado.sv
// Tic-tac-toe game state: takes move requests from the position selector,
// validates and commits them alternately for X and O, and detects win/draw.
module tablero_estado
    import tablero_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic [3:0]  pos,
    input  logic        Ready,
    output logic [17:0] board,
    output logic        turn,
    output logic        move_ack,
    output logic        invalid,
    output logic        game_over,
    output logic [1:0]  winner
);

    state_t               state_reg, state_next;
    logic [BOARD_W-1:0]   board_reg, board_next;
    logic                 turn_reg, turn_next;
    logic [3:0]           pos_q_reg, pos_q_next;
    logic [3:0]           count_reg, count_next;
    logic                 ack_reg, ack_next;
    logic                 invalid_reg, invalid_next;
    logic                 game_over_reg, game_over_next;
    winner_t              winner_reg, winner_next;
    logic                 ready_q_reg;

    logic                 clear;
    logic                 request;
    logic [NUM_CELLS-1:0] cell_sel;
    logic [NUM_CELLS-1:0] cell_full;
    logic                 cell_taken;
    logic                 pos_bad;
    logic                 line_win;

    assign clear   = reset | new_game;
    assign request = Ready & ~ready_q_reg;

    // One-hot decode of the latched position and occupancy of every cell.
    generate
        for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            assign cell_sel[gi]  = (pos_q_reg == 4'(gi));
            assign cell_full[gi] = |board_reg[2*gi +: 2];
        end
    endgenerate

    assign cell_taken = |(cell_sel & cell_full);
    assign pos_bad    = (pos_q_reg > 4'd8);

    // Evaluated against the already-committed board, so the mover's new mark counts.
    linea_ganadora u_linea (
        .board  (board_reg),
        .player (turn_reg),
        .win    (line_win)
    );

    always_comb begin
        state_next     = state_reg;
        board_next     = board_reg;
        turn_next      = turn_reg;
        pos_q_next     = pos_q_reg;
        count_next     = count_reg;
        ack_next       = 1'b0;
        invalid_next   = 1'b0;
        game_over_next = game_over_reg;
        winner_next    = winner_reg;

        case (state_reg)
            ST_WAIT: begin
                if (request) begin
                    pos_q_next = pos;
                    state_next = ST_COMMIT;
                end
            end

            ST_COMMIT: begin
                if (pos_bad || cell_taken) begin
                    invalid_next = 1'b1;
                    state_next   = ST_WAIT;
                end else begin
                    for (int i = 0; i < NUM_CELLS; i++) begin
                        if (cell_sel[i]) begin
                            board_next[2*i +: 2] = mark_of(turn_reg);
                        end
                    end
                    count_next = count_reg + 4'd1;
                    state_next = ST_EVAL;
                end
            end

            ST_EVAL: begin
                if (line_win) begin
                    winner_next    = winner_of(turn_reg);
                    game_over_next = 1'b1;
                    state_next     = ST_DONE;
                end else if (count_reg == 4'd9) begin
                    winner_next    = WIN_DRAW;
                    game_over_next = 1'b1;
                    state_next     = ST_DONE;
                end else begin
                    turn_next  = ~turn_reg;
                    ack_next   = 1'b1;
                    state_next = ST_WAIT;
                end
            end

            ST_DONE: begin
                state_next = ST_DONE;
            end

            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg     <= ST_WAIT;
            board_reg     <= '0;
            turn_reg      <= FIRST_PLAYER;
            pos_q_reg     <= '0;
            count_reg     <= '0;
            ack_reg       <= 1'b0;
            invalid_reg   <= 1'b0;
            game_over_reg <= 1'b0;
            winner_reg    <= WIN_NONE;
            ready_q_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            board_reg     <= board_next;
            turn_reg      <= turn_next;
            pos_q_reg     <= pos_q_next;
            count_reg     <= count_next;
            ack_reg       <= ack_next;
            invalid_reg   <= invalid_next;
            game_over_reg <= game_over_next;
            winner_reg    <= winner_next;
            ready_q_reg   <= Ready;
        end
    end

    assign board     = board_reg;
    assign turn      = turn_reg;
    assign move_ack  = ack_reg;
    assign invalid   = invalid_reg;
    assign game_over = game_over_reg;
    assign winner    = winner_reg;

endmodule

// File: tb/tb_tablero_estado.sv
// Scoreboard bench for tablero_estado: two instances (X first, O first) share
// stimulus; a game-rules model queues expected events, a monitor pops them.
module tb_tablero_estado;

    logic        clk;
    logic        reset;
    logic        new_game;
    logic [3:0]  pos;
    logic        Ready;

    logic [17:0] board0, board1;
    logic        turn0, turn1;
    logic        ack0, ack1;
    logic        inv0, inv1;
    logic        go0, go1;
    logic [1:0]  win0, win1;

    tablero_estado #(.FIRST_PLAYER(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .new_game(new_game), .pos(pos), .Ready(Ready),
        .board(board0), .turn(turn0), .move_ack(ack0), .invalid(inv0),
        .game_over(go0), .winner(win0)
    );

    tablero_estado #(.FIRST_PLAYER(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .new_game(new_game), .pos(pos), .Ready(Ready),
        .board(board1), .turn(turn1), .move_ack(ack1), .invalid(inv1),
        .game_over(go1), .winner(win1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = move accepted, 1 = rejected, 2 = game ended
    typedef struct {
        int          kind;
        logic [17:0] board;
        logic        turn;
        logic [1:0]  winner;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    int mcell[2][9];
    int mturn[2];
    bit mover[2];
    int fp[2] = '{0, 1};
    bit go_prev[2] = '{1'b0, 1'b0};

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 9; i++) mcell[d][i] = 0;
            mturn[d] = fp[d];
            mover[d] = 1'b0;
        end
    endtask

    function automatic logic [17:0] pack_board(int d);
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mcell[d][i]);
        return b;
    endfunction

    function automatic bit has_line(int d, int m);
        for (int r = 0; r < 3; r++)
            if (mcell[d][3*r] == m && mcell[d][3*r+1] == m && mcell[d][3*r+2] == m) return 1'b1;
        for (int c = 0; c < 3; c++)
            if (mcell[d][c] == m && mcell[d][c+3] == m && mcell[d][c+6] == m) return 1'b1;
        if (mcell[d][0] == m && mcell[d][4] == m && mcell[d][8] == m) return 1'b1;
        if (mcell[d][2] == m && mcell[d][4] == m && mcell[d][6] == m) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit board_full(int d);
        for (int i = 0; i < 9; i++) if (mcell[d][i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_request(int p);
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!mover[d]) begin
                e.winner = 2'b00;
                if (p > 8 || mcell[d][p] != 0) begin
                    e.kind = 1;
                end else begin
                    mcell[d][p] = mturn[d] + 1;
                    if (has_line(d, mturn[d] + 1)) begin
                        e.kind = 2;
                        e.winner = 2'(mturn[d] + 1);
                        mover[d] = 1'b1;
                    end else if (board_full(d)) begin
                        e.kind = 2;
                        e.winner = 2'b11;
                        mover[d] = 1'b1;
                    end else begin
                        e.kind = 0;
                        mturn[d] = 1 - mturn[d];
                    end
                end
                e.board = pack_board(d);
                e.turn  = mturn[d][0];
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    // ---------------- monitor ----------------
    task automatic check_dut(int d, logic ack, logic inv, logic go,
                             logic [17:0] brd, logic trn, logic [1:0] win);
        exp_t e;
        int   kind;
        bit   rise;
        bit   empty;
        rise = go & ~go_prev[d];
        go_prev[d] = go;
        if (ack || inv || rise) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            checks++;
            if (empty) begin
                errors++;
                $display("FAIL unexpected_event dut%0d: ack=%b invalid=%b game_over=%b board=%h, required no event",
                         d, ack, inv, go, brd);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                kind = rise ? 2 : (inv ? 1 : 0);
                if (kind != e.kind || ack != (e.kind == 0) || inv != (e.kind == 1) ||
                    brd != e.board || trn != e.turn || win != e.winner) begin
                    errors++;
                    $display("FAIL event dut%0d: got kind=%0d ack=%b inv=%b board=%h turn=%b winner=%b, required kind=%0d board=%h turn=%b winner=%b",
                             d, kind, ack, inv, brd, trn, win, e.kind, e.board, e.turn, e.winner);
                end else begin
                    $display("dut%0d event kind=%0d board=%h turn=%b winner=%b ok", d, kind, brd, trn, win);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, ack0, inv0, go0, board0, turn0, win0);
        check_dut(1, ack1, inv1, go1, board1, turn1, win1);
    end

    // ---------------- driver helpers ----------------
    task automatic expect_val(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_move(int p, int hold, int low);
        @(negedge clk);
        pos = 4'(p);
        Ready = 1'b1;
        model_request(p);
        repeat (hold) @(negedge clk);
        Ready = 1'b0;
        repeat (low - 1) @(negedge clk);
    endtask

    task automatic new_game_pulse();
        idle(3);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
    endtask

    task automatic play(int seq[], int n);
        for (int i = 0; i < n; i++) do_move(seq[i], 1, 3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int win_seq[5];
        int draw_seq[9];
        int p, hold, low;

        win_seq  = '{0, 3, 1, 4, 2};
        draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

        reset = 1'b1; new_game = 1'b0; pos = 4'd0; Ready = 1'b0;
        model_reset();
        idle(3);
        reset = 1'b0;
        expect_val("reset_board0", 32'(board0), 32'h0);
        expect_val("reset_turn0", 32'(turn0), 32'h0);
        expect_val("reset_turn1", 32'(turn1), 32'h1);
        expect_val("reset_over_winner0", {29'h0, go0, win0}, 32'h0);

        // First move at centre, with latency checks at k and k+1.
        pos = 4'd4; Ready = 1'b1;
        model_request(4);
        @(negedge clk);
        Ready = 1'b0;
        expect_val("k0_board0", 32'(board0), 32'h0);
        @(negedge clk);
        expect_val("k1_cell4_dut0", 32'(board0[9:8]), 32'h1);
        expect_val("k1_cell4_dut1", 32'(board1[9:8]), 32'h2);
        expect_val("k1_no_ack", 32'(ack0), 32'h0);
        @(negedge clk);
        expect_val("k2_turn0", 32'(turn0), 32'h1);
        idle(2);

        do_move(4, 1, 3);
        do_move(12, 2, 2);

        new_game_pulse();
        play(win_seq, 5);
        do_move(5, 1, 3);
        do_move(6, 2, 3);

        new_game_pulse();
        play(draw_seq, 9);

        new_game_pulse();
        do_move(0, 5, 1);
        do_move(1, 1, 3);

        // new_game while the move is in EVAL: nothing should be acknowledged.
        new_game_pulse();
        pos = 4'd0; Ready = 1'b1;
        @(negedge clk);
        Ready = 1'b0;
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
        expect_val("ng_eval_board0", 32'(board0), 32'h0);
        expect_val("ng_eval_board1", 32'(board1), 32'h0);
        expect_val("ng_eval_turn0", 32'(turn0), 32'h0);
        expect_val("ng_eval_turn1", 32'(turn1), 32'h1);
        idle(3);

        // reset together with a Ready rise, Ready then held past reset.
        reset = 1'b1; Ready = 1'b1; pos = 4'd7;
        @(negedge clk);
        expect_val("rst_ready_board0", 32'(board0), 32'h0);
        expect_val("rst_ready_board1", 32'(board1), 32'h0);
        reset = 1'b0;
        model_reset();
        model_request(7);
        @(negedge clk);
        Ready = 1'b0;
        idle(4);

        // Randomized games.
        for (int g = 0; g < 8; g++) begin
            new_game_pulse();
            for (int m = 0; m < 16 && !mover[0]; m++) begin
                p = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 15));
                hold = $urandom_range(1, 5);
                low = ((hold >= 2) ? 1 : 3 - hold) + $urandom_range(0, 2);
                do_move(p, hold, low);
            end
            if (mover[0]) do_move($urandom_range(0, 8), 1, 3);
        end

        idle(6);
        expect_val("queue0_drained", 32'(q0.size()), 32'h0);
        expect_val("queue1_drained", 32'(q1.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
